// File: rtl/secded_link_pkg.sv
`default_nettype none
// ============================================================================
// Module  : secded_link_pkg
// Purpose : Shared types and constants for the SECDED byte link transmitter:
//           transmitter state encoding, frame/code sizes, codeword position
//           constants and parity coverage masks.
// Ports   : none (package)
// Options : TX_ERR_INJECT_EN selects error-injection positions used by the
//           transmitter; the constants below exist in every build.
// Rev     : 1.0  initial release
// ============================================================================
package secded_link_pkg;

  localparam int FRAME_BITS = 15;  // start + 13 code bits + stop
  localparam int CODE_BITS  = 13;

  // Byte the link receiver reports for an uncorrectable codeword.
  localparam logic [7:0] ERR_BYTE = 8'h15;

  typedef logic [CODE_BITS-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // Hamming parity positions inside the codeword; code[0] is overall parity.
  localparam int P1_POS  = 1;
  localparam int P2_POS  = 2;
  localparam int P4_POS  = 4;
  localparam int P8_POS  = 8;
  localparam int PALL_POS = 0;

  // Data bit placement: code[12:9]=msg[7:4], code[7:5]=msg[3:1], code[3]=msg[0].
  localparam int D_HI_TOP  = 12;
  localparam int D_HI_BOT  = 9;
  localparam int D_MID_TOP = 7;
  localparam int D_MID_BOT = 5;
  localparam int D_LO_POS  = 3;

  // Data positions covered by each parity bit (position index has that bit set).
  localparam code_t P1_MASK = 13'b0_1010_1010_1000;  // 3,5,7,9,11
  localparam code_t P2_MASK = 13'b0_1100_1100_1000;  // 3,6,7,10,11
  localparam code_t P4_MASK = 13'b1_0000_1110_0000;  // 5,6,7,12
  localparam code_t P8_MASK = 13'b1_1110_0000_0000;  // 9,10,11,12

  // Codeword bits flipped by error injection (single, then double).
  localparam int ERR_POS_A = 5;
  localparam int ERR_POS_B = 10;

endpackage : secded_link_pkg
`default_nettype wire

// File: rtl/secded_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module  : secded_transmitter_if
// Purpose : Send-side handshake bundle of the SECDED transmitter.
// Signals : messageByte [7:0] byte to send (master -> slave)
//           send              request to send      (master -> slave)
//           ready             send accepted now    (slave -> master)
//           errInject [1:0]   error injection code (master -> slave),
//                             present only with TX_ERR_INJECT_EN defined
// Rev     : 1.0  initial release
// ============================================================================
interface secded_transmitter_if;

  logic [7:0] messageByte;
  logic       send;
  logic       ready;
`ifdef TX_ERR_INJECT_EN
  logic [1:0] errInject;

  modport master (output messageByte, output send, output errInject, input ready);
  modport slave  (input messageByte, input send, input errInject, output ready);
`else
  modport master (output messageByte, output send, input ready);
  modport slave  (input messageByte, input send, output ready);
`endif

endinterface : secded_transmitter_if
`default_nettype wire

// File: rtl/secded_encoder.sv
`default_nettype none
// ============================================================================
// Module  : secded_encoder
// Purpose : Combinational SECDED encoder, 8-bit message -> 13-bit codeword
//           (Hamming parity at positions 1,2,4,8 plus even overall parity
//           at position 0).
// Ports   : msg  [7:0]  input message byte
//           code [12:0] encoded codeword
// Rev     : 1.0  initial release
// ============================================================================
module secded_encoder
  import secded_link_pkg::*;
(
  input  logic [7:0] msg,
  output code_t      code
);

  code_t data;

  always_comb begin
    data = '0;
    data[D_HI_TOP:D_HI_BOT]   = msg[7:4];
    data[D_MID_TOP:D_MID_BOT] = msg[3:1];
    data[D_LO_POS]            = msg[0];

    code         = data;
    code[P1_POS] = ^(data & P1_MASK);
    code[P2_POS] = ^(data & P2_MASK);
    code[P4_POS] = ^(data & P4_MASK);
    code[P8_POS] = ^(data & P8_MASK);
    // Overall parity covers data and Hamming parity bits alike.
    code[PALL_POS] = ^code[CODE_BITS-1:1];
  end

endmodule : secded_encoder
`default_nettype wire

// File: rtl/secded_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : secded_transmitter
// Purpose : Serial SECDED link transmitter. Accepts a byte on a valid/ready
//           handshake, encodes it and shifts out start(1), 13 code bits MSB
//           first, stop(0). Line idles low.
// Ports   : clock          clock, posedge
//           reset_n        asynchronous active-low reset
//           tx (slave)     messageByte/send/ready (+errInject) handshake
//           serialOut      registered serial line
//           busy           frame in progress
// Params  : IDLE_GAP       forced low cycles between stop bit and next start
// Options : TX_ERR_INJECT_EN adds errInject[1:0] to the handshake bundle.
// Rev     : 1.0  initial release
// ============================================================================
module secded_transmitter
  import secded_link_pkg::*;
#(
  parameter int IDLE_GAP = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  secded_transmitter_if.slave  tx,
  output logic                 serialOut,
  output logic                 busy
);

  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [3:0] LAST_CODE_CNT = 4'(FRAME_BITS - 2);

  tx_state_t              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   serial_q, serial_d;

  code_t code_clean;
  code_t err_mask;
  code_t code_tx;
  logic  accept;

  secded_encoder u_encoder (
    .msg  (tx.messageByte),
    .code (code_clean)
  );

`ifdef TX_ERR_INJECT_EN
  always_comb begin
    err_mask = '0;
    case (tx.errInject)
      2'b01: err_mask[ERR_POS_A] = 1'b1;
      2'b10,
      2'b11: begin
        err_mask[ERR_POS_A] = 1'b1;
        err_mask[ERR_POS_B] = 1'b1;
      end
      default: err_mask = '0;
    endcase
  end
`else
  assign err_mask = '0;
`endif

  assign code_tx  = code_clean ^ err_mask;
  assign tx.ready = (state_q == IDLE);
  assign accept   = tx.send && tx.ready;

  // The stop-bit cycle already leaves SEND: with no gap it is an IDLE
  // (ready) cycle, otherwise it is the first GAP cycle. Either way the
  // number of low cycles between stop bit and the next start equals IDLE_GAP.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    serial_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;  // wraps from 14 after the stop-bit cycle
        if (accept) begin
          // Start bit goes straight to the line; the remainder waits in
          // the shift register MSB-aligned, stop bit trailing as 0.
          serial_d = 1'b1;
          shift_d  = {code_tx, 2'b00};
          state_d  = SEND;
        end
      end

      SEND: begin
        serial_d = shift_q[FRAME_BITS-1];
        shift_d  = {shift_q[FRAME_BITS-2:0], 1'b0};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LAST_CODE_CNT) begin
          if (IDLE_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(IDLE_GAP);
          end
        end
      end

      GAP: begin
        cnt_d = '0;
        if (gap_q == GAP_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      serial_q <= serial_d;
    end
  end

  assign serialOut = serial_q;
  assign busy      = (state_q != IDLE);

endmodule : secded_transmitter
`default_nettype wire

// File: tb/tb_secded_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_secded_transmitter
// Purpose : Directed self-checking bench for secded_transmitter. Two
//           instances: IDLE_GAP=0 (dut0) and IDLE_GAP=3 (dut3); a select
//           signal steers the shared stimulus to one of them.
// Options : TX_ERR_INJECT_EN enables the error-injection frames.
// Rev     : 1.0  initial release
// ============================================================================
module tb_secded_transmitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;        // 0: dut0, 1: dut3
  logic       drv_send = 1'b0;
  logic [7:0] drv_msg = 8'h00;
`ifdef TX_ERR_INJECT_EN
  logic [1:0] drv_err = 2'b00;
`endif

  int tests = 0;
  int fails = 0;

  secded_transmitter_if if0 ();
  secded_transmitter_if if3 ();

  assign if0.send        = drv_send & ~sel;
  assign if3.send        = drv_send & sel;
  assign if0.messageByte = drv_msg;
  assign if3.messageByte = drv_msg;
`ifdef TX_ERR_INJECT_EN
  assign if0.errInject   = drv_err;
  assign if3.errInject   = drv_err;
`endif

  logic ser0, busy0, ser3, busy3;

  secded_transmitter #(.IDLE_GAP(0)) dut0 (
    .clock     (clk),
    .reset_n   (rst_n),
    .tx        (if0),
    .serialOut (ser0),
    .busy      (busy0)
  );

  secded_transmitter #(.IDLE_GAP(3)) dut3 (
    .clock     (clk),
    .reset_n   (rst_n),
    .tx        (if3),
    .serialOut (ser3),
    .busy      (busy3)
  );

  logic line, rdy, bsy;
  assign line = sel ? ser3 : ser0;
  assign rdy  = sel ? if3.ready : if0.ready;
  assign bsy  = sel ? busy3 : busy0;

  // Hand-computed frames {start, code[12:0], stop}.
  localparam logic [14:0] F_00 = {1'b1, 13'b0000000000000, 1'b0};
  localparam logic [14:0] F_01 = {1'b1, 13'b0000000001111, 1'b0};
  localparam logic [14:0] F_FF = {1'b1, 13'b1111011101110, 1'b0};
`ifdef TX_ERR_INJECT_EN
  localparam logic [14:0] F_A5_E1 = {1'b1, 13'b1010001101110, 1'b0};
  localparam logic [14:0] F_A5_E2 = {1'b1, 13'b1000001101110, 1'b0};
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, let it be accepted on the next edge, then scramble the
  // input byte so a late change would corrupt the frame.
  task automatic start(input logic [7:0] m);
    drv_msg  = m;
    drv_send = 1'b1;
    tick();
    drv_send = 1'b0;
    drv_msg  = ~m;
  endtask

  // Sample the 15 frame bits starting at the first post-accept cycle.
  // Optionally pulses send at bit pulse_k (must be ignored), and with
  // chain set, presents the next byte during the stop-bit cycle.
  task automatic grab(output logic [14:0] f, output logic b_first,
                      output logic r_last, output logic b_last,
                      input int pulse_k, input logic chain, input logic [7:0] nm);
    for (int k = 0; k < 15; k++) begin
      f[14-k] = line;
      if (k == 0) b_first = bsy;
      if (k == pulse_k) drv_send = 1'b1;
      if (k == pulse_k + 1) drv_send = 1'b0;
      if (k == 14) begin
        r_last = rdy;
        b_last = bsy;
        if (chain) begin
          drv_msg  = nm;
          drv_send = 1'b1;
        end
      end else begin
        tick();
      end
    end
  endtask

  logic [14:0] fr;
  logic        bf, rl, bl;
  logic [32:0] stream;
  logic [32:0] rdy_trace;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_serial", ser0, 1'b0);
    check("rst_busy",   busy0, 1'b0);
    check("rst_ready",  if0.ready, 1'b1);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", if0.ready, 1'b1);
    check("post_rst_busy",  busy0, 1'b0);
    check("post_rst_line",  ser0, 1'b0);

    // ---------------- 8'h00 ----------------
    start(8'h00);
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_00", fr, F_00);
    check("busy_first_00", bf, 1'b1);
    check("ready_stop_00", rl, 1'b1);
    check("busy_stop_00",  bl, 1'b0);
    tick();

    // ---------------- 8'h01, stray send mid-frame ----------------
    start(8'h01);
    grab(fr, bf, rl, bl, 5, 1'b0, 8'h00);
    check("frame_01", fr, F_01);
    tick();
    check("no_queue_line", ser0, 1'b0);
    check("no_queue_busy", busy0, 1'b0);
    tick();
    check("no_queue_line2", ser0, 1'b0);

    // ---------------- 8'hFF then 8'h00 back-to-back ----------------
    start(8'hFF);
    grab(fr, bf, rl, bl, 99, 1'b1, 8'h00);
    check("frame_FF_b2b", fr, F_FF);
    check("ready_stop_FF", rl, 1'b1);
    tick();
    drv_send = 1'b0;
    drv_msg  = 8'hFF;
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_00_b2b", fr, F_00);
    tick();

    // ---------------- reset mid-frame ----------------
    start(8'hFF);
    for (int k = 0; k < 6; k++) tick();
    check("abort_bit6_before", ser0, F_FF[14-6]);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_line",  ser0, 1'b0);
    check("abort_busy",  busy0, 1'b0);
    check("abort_ready", if0.ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_post_ready", if0.ready, 1'b1);
    check("abort_post_busy",  busy0, 1'b0);
    check("abort_post_line",  ser0, 1'b0);
    start(8'h01);
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_01_after_abort", fr, F_01);
    tick();

`ifdef TX_ERR_INJECT_EN
    // ---------------- error injection on 8'hA5 ----------------
    drv_err = 2'b01;
    start(8'hA5);
    drv_err = 2'b00;
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_A5_err01", fr, F_A5_E1);
    tick();
    drv_err = 2'b10;
    start(8'hA5);
    drv_err = 2'b00;
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_A5_err10", fr, F_A5_E2);
    tick();
    drv_err = 2'b11;
    start(8'hA5);
    drv_err = 2'b00;
    grab(fr, bf, rl, bl, 99, 1'b0, 8'h00);
    check("frame_A5_err11", fr, F_A5_E2);
    tick();
`endif

    // ---------------- IDLE_GAP=3, send held high ----------------
    sel = 1'b1;
    tick();
    check("gap_idle_ready", if3.ready, 1'b1);
    drv_msg  = 8'hFF;
    drv_send = 1'b1;
    tick();
    drv_msg = 8'h01;  // only the second accept may pick this up
    for (int k = 0; k < 33; k++) begin
      stream[32-k]    = line;
      rdy_trace[32-k] = rdy;
      if (k == 14) check("gap_busy_stop", bsy, 1'b1);
      if (k == 16) check("gap_busy_gap",  bsy, 1'b1);
      if (k < 32) tick();
    end
    drv_send = 1'b0;
    check("gap_stream", stream, {F_FF, 3'b000, F_01});
    // Ready only in the last of the three low cycles.
    check("gap_ready_window", rdy_trace[32-14 -: 4], 4'b0001);
    tick();
    tick();
    tick();
    tick();
    check("gap_final_ready", if3.ready, 1'b1);
    check("gap_final_busy",  busy3, 1'b0);
    check("gap_final_line",  ser3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_secded_transmitter
`default_nettype wire
